// File: rtl/spi_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_rx_pkg : register map and bit positions shared by spi_rx         |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
package spi_rx_pkg;

  localparam logic [1:0] SPI_RX_STATUS = 2'd0;
  localparam logic [1:0] SPI_RX_DATA   = 2'd1;
  localparam logic [1:0] SPI_RX_CTRL   = 2'd2;

  localparam int c_stat_nempty  = 0;
  localparam int c_stat_full    = 1;
  localparam int c_stat_ovr     = 2;
  localparam int c_stat_ferr    = 3;
  localparam int c_stat_busy    = 4;
  localparam int c_stat_cnt_lsb = 5;

  localparam int c_ctrl_en     = 0;
  localparam int c_ctrl_ie     = 1;
  localparam int c_ctrl_flush  = 2;
  localparam int c_ctrl_to_lsb = 8;

  localparam logic [31:0] c_ctrl_reset = 32'h0000_0001;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo : single-clock FIFO with flush; push while full is only    |
// |             accepted when a pop happens on the same edge             |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [c_aw-1:0]   r_wr_ptr;
  logic [c_aw-1:0]   r_rd_ptr;
  logic [c_aw:0]     r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (c_aw+1)'(DEPTH));
  assign w_do_pop  = pop & ~empty;
  // The head slot is read combinationally before the edge, so a full FIFO
  // may overwrite it in the same cycle it is popped.
  assign w_do_push = push & (~full | w_do_pop);
  assign head      = r_mem[r_rd_ptr];
  assign count     = r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/spi_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_rx   : SPI receive deserializer (MSB-first words) with a FIFO    |
// |            and a 4-register processor window                         |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module spi_rx
  import spi_rx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WORD  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_clk_in,
  input  logic        spi_din,
  input  logic [31:0] data_in,
  input  logic [1:0]  addr,
  input  logic        write_en,
  input  logic        rd_en,
  input  logic        cs_n,
  output logic [31:0] data_out,
  output logic        irq
);

  localparam int c_bw = $clog2(WORD);
  localparam int c_cw = $clog2(DEPTH) + 1;

  logic [1:0]       r_clk_sync;
  logic [1:0]       r_din_sync;
  logic             r_clk_prev;
  logic [WORD-1:0]  r_sh;
  logic [c_bw-1:0]  r_bit_cnt;
  logic [7:0]       r_idle_cnt;
  logic             r_en;
  logic             r_ie;
  logic [7:0]       r_timeout;
  logic             r_ovr;
  logic             r_ferr;

  logic             w_edge;
  logic             w_wr;
  logic             w_stat_wr;
  logic             w_ctrl_wr;
  logic             w_flush;
  logic             w_shift;
  logic             w_complete;
  logic [WORD-1:0]  w_word;
  logic             w_pop;
  logic             w_push;
  logic             w_ovr_set;
  logic             w_timeout;
  logic             w_ferr_set;
  logic [WORD-1:0]  w_head;
  logic [c_cw-1:0]  w_count;
  logic             w_full;
  logic             w_empty;
  logic [31:0]      w_rdata;
  logic             w_unused;

  assign w_edge     = r_clk_sync[1] & ~r_clk_prev;
  assign w_wr       = ~cs_n & write_en;
  assign w_stat_wr  = w_wr & (addr == SPI_RX_STATUS);
  assign w_ctrl_wr  = w_wr & (addr == SPI_RX_CTRL);
  assign w_flush    = w_ctrl_wr & data_in[c_ctrl_flush];
  assign w_shift    = w_edge & r_en;
  assign w_word     = {r_sh[WORD-2:0], r_din_sync[1]};
  assign w_complete = w_shift & (r_bit_cnt == c_bw'(WORD-1));
  assign w_pop      = ~cs_n & rd_en & (addr == SPI_RX_DATA) & ~w_empty;
  assign w_push     = w_complete & ~w_flush & (~w_full | w_pop);
  assign w_ovr_set  = w_complete & ~w_flush & w_full & ~w_pop;
  // A rising edge clears the idle counter, so it always beats a timeout.
  assign w_timeout  = ~w_edge & (r_bit_cnt != '0) & (r_timeout != 8'd0) &
                      (r_idle_cnt == r_timeout);
  assign w_ferr_set = w_timeout & ~w_flush;
  assign w_unused   = ^{data_in[31:16], data_in[7:4]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk_sync <= '0;
      r_din_sync <= '0;
      r_clk_prev <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[0], spi_clk_in};
      r_din_sync <= {r_din_sync[0], spi_din};
      r_clk_prev <= r_clk_sync[1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sh      <= '0;
      r_bit_cnt <= '0;
    end else if (w_flush) begin
      r_sh      <= '0;
      r_bit_cnt <= '0;
    end else if (w_shift) begin
      r_sh      <= w_word;
      r_bit_cnt <= w_complete ? '0 : r_bit_cnt + 1'b1;
    end else if (w_timeout) begin
      r_bit_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     r_idle_cnt <= '0;
    else if (w_edge)              r_idle_cnt <= '0;
    else if (r_idle_cnt != 8'hFF) r_idle_cnt <= r_idle_cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en      <= c_ctrl_reset[c_ctrl_en];
      r_ie      <= c_ctrl_reset[c_ctrl_ie];
      r_timeout <= c_ctrl_reset[c_ctrl_to_lsb +: 8];
    end else if (w_ctrl_wr) begin
      r_en      <= data_in[c_ctrl_en];
      r_ie      <= data_in[c_ctrl_ie];
      r_timeout <= data_in[c_ctrl_to_lsb +: 8];
    end
  end

  // Sticky flags: a new set in the same cycle as a W1C wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovr  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      r_ovr  <= (r_ovr  & ~(w_stat_wr & data_in[c_stat_ovr]))  | w_ovr_set;
      r_ferr <= (r_ferr & ~(w_stat_wr & data_in[c_stat_ferr])) | w_ferr_set;
    end
  end

  sync_fifo #(
    .WIDTH (WORD),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_flush),
    .din   (w_word),
    .head  (w_head),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_comb begin
    w_rdata = '0;
    case (addr)
      SPI_RX_STATUS: begin
        w_rdata[c_stat_nempty]            = ~w_empty;
        w_rdata[c_stat_full]              = w_full;
        w_rdata[c_stat_ovr]               = r_ovr;
        w_rdata[c_stat_ferr]              = r_ferr;
        w_rdata[c_stat_busy]              = (r_bit_cnt != '0);
        w_rdata[c_stat_cnt_lsb +: c_cw]   = w_count;
      end
      SPI_RX_DATA: begin
        if (!w_empty) w_rdata = 32'(w_head);
      end
      SPI_RX_CTRL: begin
        w_rdata[c_ctrl_en]             = r_en;
        w_rdata[c_ctrl_ie]             = r_ie;
        w_rdata[c_ctrl_to_lsb +: 8]    = r_timeout;
      end
      default: w_rdata = '0;
    endcase
  end

  assign data_out = cs_n ? 'z : w_rdata;
  assign irq      = ~w_empty & r_ie;

endmodule
`default_nettype wire

// File: tb/tb_spi_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_spi_rx : randomized bench for spi_rx with a queue-based model     |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module tb_spi_rx;
  import spi_rx_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        spi_clk_in = 1'b0;
  logic        spi_din = 1'b0;
  logic [31:0] data_in = '0;
  logic [1:0]  addr = '0;
  logic        write_en = 1'b0;
  logic        rd_en = 1'b0;
  logic        cs_n = 1'b1;
  logic [31:0] data_out;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  spi_rx #(.DEPTH(DEPTH), .WORD(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .spi_clk_in (spi_clk_in),
    .spi_din    (spi_din),
    .data_in    (data_in),
    .addr       (addr),
    .write_en   (write_en),
    .rd_en      (rd_en),
    .cs_n       (cs_n),
    .data_out   (data_out),
    .irq        (irq)
  );

  // Reference model: a sampled rising edge on the line is applied two
  // clocks after it is first seen; words live in a queue.
  typedef struct { int due; bit d; } ev_t;
  ev_t         pend[$];
  int          cyc = 0;
  bit          prev_c;
  bit          m_en, m_ie, m_ovr, m_ferr;
  logic [7:0]  m_to;
  int          m_bits, m_idle;
  logic [31:0] m_part;
  logic [31:0] m_q[$];

  always @(posedge clk) begin : model
    bit          e, dn, wr, flush, pop, complete, tmo, ovr_set, ferr_set;
    logic [31:0] word, tmp;
    ev_t         ev;
    cyc++;
    if (!rst) begin
      pend.delete(); m_q.delete();
      prev_c = 0; m_en = 1; m_ie = 0; m_to = 0; m_ovr = 0; m_ferr = 0;
      m_bits = 0; m_idle = 0; m_part = 0;
    end else begin
      e = 0; dn = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        ev = pend.pop_front(); e = 1; dn = ev.d;
      end
      if (spi_clk_in && !prev_c) pend.push_back('{cyc + 2, spi_din});
      prev_c = spi_clk_in;

      wr       = !cs_n && write_en;
      flush    = wr && addr == SPI_RX_CTRL && data_in[2];
      pop      = !cs_n && rd_en && addr == SPI_RX_DATA && m_q.size() > 0;
      complete = e && m_en && m_bits == 31;
      word     = {m_part[30:0], dn};
      tmo      = !e && m_bits != 0 && m_to != 0 && m_idle == int'(m_to);
      ovr_set  = 0; ferr_set = 0;

      if (pop) tmp = m_q.pop_front();
      if (complete && !flush) begin
        if (m_q.size() < DEPTH) m_q.push_back(word);
        else ovr_set = 1;
      end
      if (flush) begin
        m_q.delete(); m_bits = 0; m_part = 0;
      end else if (e && m_en) begin
        m_part = word; m_bits = (m_bits + 1) % 32;
      end else if (tmo) begin
        m_bits = 0; ferr_set = 1;
      end
      m_idle = e ? 0 : (m_idle < 255 ? m_idle + 1 : 255);
      if (wr && addr == SPI_RX_STATUS) begin
        if (data_in[2]) m_ovr = 0;
        if (data_in[3]) m_ferr = 0;
      end
      m_ovr  = m_ovr | ovr_set;
      m_ferr = m_ferr | ferr_set;
      if (wr && addr == SPI_RX_CTRL) begin
        m_en = data_in[0]; m_ie = data_in[1]; m_to = data_in[15:8];
      end
    end
  end

  function automatic logic [31:0] m_read(logic [1:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      2'd0: begin
        r[0] = m_q.size() > 0;
        r[1] = m_q.size() == DEPTH;
        r[2] = m_ovr;
        r[3] = m_ferr;
        r[4] = m_bits != 0;
        r[9:5] = 5'(m_q.size());
      end
      2'd1: r = (m_q.size() > 0) ? m_q[0] : 32'h0;
      2'd2: r = {16'h0, m_to, 5'b0, 1'b0, m_ie, m_en};
      default: r = '0;
    endcase
    return r;
  endfunction

  always @(negedge clk) begin : compare
    logic [31:0] want;
    bit          irq_want;
    if (rst) begin
      irq_want = (m_q.size() > 0) && m_ie;
      n_cmp++;
      if (irq !== irq_want) begin
        n_bad++;
        $display("FAIL irq @%0t: got %b want %b", $time, irq, irq_want);
      end
      if (!cs_n) begin
        want = m_read(addr);
        n_cmp++;
        if (data_out !== want) begin
          n_bad++;
          $display("FAIL read addr%0d @%0t: got %h want %h", addr, $time, data_out, want);
        end
      end
    end
  end

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic bus_idle();
    int a;
    a = $urandom_range(0, 2);
    cs_n = 1'b0; write_en = 1'b0; rd_en = 1'b0;
    addr = (a == 0) ? 2'd0 : 2'(a + 1);
    data_in = $urandom;
  endtask

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; bus_idle(); end
  endtask

  task automatic bus_write(logic [1:0] a, logic [31:0] d);
    @(posedge clk); #1;
    cs_n = 1'b0; write_en = 1'b1; rd_en = 1'b0; addr = a; data_in = d;
    @(posedge clk); #1; bus_idle();
  endtask

  task automatic bus_read(logic [1:0] a, bit pop, output logic [31:0] got);
    @(posedge clk); #1;
    cs_n = 1'b0; write_en = 1'b0; rd_en = pop; addr = a;
    @(negedge clk); got = data_out;
    @(posedge clk); #1; bus_idle();
  endtask

  // Data changes with the falling edge; pop_here drives a DATA pop in the
  // cycle just before this bit is shifted in.
  task automatic send_bit(bit b, int half, bit pop_here, logic [31:0] pop_want);
    @(posedge clk); #1; spi_clk_in = 1'b0; spi_din = b; bus_idle();
    repeat (half - 1) begin @(posedge clk); #1; bus_idle(); end
    @(posedge clk); #1; spi_clk_in = 1'b1; bus_idle();
    for (int i = 1; i < half; i++) begin
      @(posedge clk); #1;
      if (pop_here && i == 2) begin
        cs_n = 1'b0; write_en = 1'b0; rd_en = 1'b1; addr = SPI_RX_DATA;
        @(negedge clk);
        check("pop on final edge", data_out, pop_want);
      end else begin
        bus_idle();
      end
    end
  endtask

  task automatic send_word(logic [31:0] w, int half, bit pop_last, logic [31:0] pop_want);
    for (int i = 31; i >= 0; i--) send_bit(w[i], half, pop_last && i == 0, pop_want);
    @(posedge clk); #1; bus_idle();
  endtask

  task automatic send_bits(int n, int half, bit val, bit rnd);
    for (int i = 0; i < n; i++) send_bit(rnd ? 1'($urandom) : val, half, 1'b0, 32'h0);
    @(posedge clk); #1; bus_idle();
  endtask

  initial begin : watchdog
    #800000;
    n_bad++;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] got;
    logic [31:0] ctrl;
    int op;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1; bus_idle();

    bus_read(SPI_RX_STATUS, 0, got); check("reset STATUS", got, 32'h0);
    bus_read(SPI_RX_CTRL, 0, got);   check("reset CTRL", got, 32'h1);
    check("reset irq", {31'b0, irq}, 32'h0);

    // single word with interrupt enabled
    bus_write(SPI_RX_CTRL, 32'h3);
    send_word(32'hA5A5_0F0F, 2, 0, 0);
    idle(4);
    bus_read(SPI_RX_STATUS, 0, got); check("one word STATUS", got, 32'h21);
    check("irq with ie", {31'b0, irq}, 32'h1);
    bus_read(SPI_RX_DATA, 1, got);   check("one word DATA", got, 32'hA5A5_0F0F);
    bus_read(SPI_RX_STATUS, 0, got); check("after pop STATUS", got, 32'h0);
    bus_write(SPI_RX_CTRL, 32'h1);

    // overrun
    for (int w = 1; w <= 5; w++) send_word(32'(w), 2, 0, 0);
    idle(4);
    bus_read(SPI_RX_STATUS, 0, got); check("overrun STATUS", got, 32'h87);
    for (int w = 1; w <= 4; w++) begin
      bus_read(SPI_RX_DATA, 1, got); check("overrun pop", got, 32'(w));
    end
    bus_read(SPI_RX_STATUS, 0, got); check("ovr sticky", got, 32'h4);
    bus_write(SPI_RX_STATUS, 32'h4);
    bus_read(SPI_RX_STATUS, 0, got); check("ovr cleared", got, 32'h0);

    // full FIFO with a pop on the edge that completes a word
    for (int w = 1; w <= 4; w++) send_word(32'h1111_1111 * w, 3, 0, 0);
    send_word(32'hCAFE_F00D, 3, 1, 32'h1111_1111);
    idle(4);
    bus_read(SPI_RX_STATUS, 0, got); check("push+pop full STATUS", got, 32'h83);
    for (int w = 2; w <= 4; w++) begin
      bus_read(SPI_RX_DATA, 1, got); check("push+pop drain", got, 32'h1111_1111 * w);
    end
    bus_read(SPI_RX_DATA, 1, got); check("push+pop tail", got, 32'hCAFE_F00D);

    // idle timeout
    bus_write(SPI_RX_CTRL, 32'h0000_1001);
    send_bits(10, 2, 0, 1);
    spi_clk_in = 1'b0;
    idle(24);
    bus_read(SPI_RX_STATUS, 0, got); check("timeout STATUS", got, 32'h8);
    send_word(32'h0BAD_BEEF, 2, 0, 0);
    idle(4);
    bus_read(SPI_RX_STATUS, 0, got); check("after timeout STATUS", got, 32'h29);
    bus_read(SPI_RX_DATA, 1, got);   check("after timeout DATA", got, 32'h0BAD_BEEF);
    bus_write(SPI_RX_STATUS, 32'h8);

    // reset in the middle of a word, line still high at release
    bus_write(SPI_RX_CTRL, 32'h1);
    send_bits(17, 2, 0, 1);
    @(posedge clk); #1; rst = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1; bus_idle();
    idle(5);
    bus_write(SPI_RX_CTRL, 32'h5);
    bus_read(SPI_RX_STATUS, 0, got); check("post-reset flush STATUS", got, 32'h0);
    bus_read(SPI_RX_CTRL, 0, got);   check("post-reset CTRL", got, 32'h1);
    send_word(32'h1234_5678, 2, 0, 0);
    idle(4);
    bus_read(SPI_RX_DATA, 1, got);   check("post-reset DATA", got, 32'h1234_5678);

    // disabled edges are ignored
    bus_write(SPI_RX_CTRL, 32'h0);
    send_bits(8, 2, 1, 0);
    bus_write(SPI_RX_CTRL, 32'h1);
    send_word(32'h00FF_00AA, 2, 0, 0);
    idle(4);
    bus_read(SPI_RX_STATUS, 0, got); check("enable STATUS", got, 32'h21);
    bus_read(SPI_RX_DATA, 1, got);   check("enable DATA", got, 32'h00FF_00AA);

    // randomized traffic checked by the model every cycle
    ctrl = {16'h0, ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(20, 40)),
            5'b0, 1'b0, 1'($urandom), 1'b1};
    bus_write(SPI_RX_CTRL, ctrl);
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 11);
      if (op <= 4)       send_word($urandom, $urandom_range(2, 4), 0, 0);
      else if (op == 5)  begin send_bits($urandom_range(1, 31), 2, 0, 1); spi_clk_in = 1'b0; idle(50); end
      else if (op <= 8)  bus_read(SPI_RX_DATA, 1, got);
      else if (op == 9)  bus_write(SPI_RX_STATUS, $urandom);
      else if (op == 10) bus_write(SPI_RX_CTRL, ctrl | 32'h4);
      else begin
        ctrl = {16'h0, 8'($urandom_range(20, 40)), 5'b0, 1'b0, 1'($urandom), 1'b1};
        bus_write(SPI_RX_CTRL, ctrl);
      end
    end
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_rx.md
# spi_rx

SPI receive deserializer for the memory-mapped peripheral space. It samples the serial line and bit clock driven by the SPI transmit peripheral, or by an external SPI master, and assembles MSB-first 32-bit words. Completed words are buffered in a small FIFO that the processor reads through a 4-register bus window. It is the consumer of `mosi`/`clk_spi` and enables loopback self-test of the transmitter.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, 2–16.
- `WORD`, 32: bits per received word.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous reset, active-low
- `spi_clk_in`  in  1  serial bit clock, asynchronous to `clk`
- `spi_din`  in  1  serial data; MSB first
- `data_in`  in  32  processor write data
- `addr`  in  2  register select
- `write_en`  in  1  write strobe, active-high, qualified by `cs_n`
- `rd_en`  in  1  read strobe, active-high; pops the FIFO on a DATA read
- `cs_n`  in  1  chip select, active-low
- `data_out`  out  32  read data; high-Z when `cs_n`=1
- `irq`  out  1  level; 1 while the FIFO is non-empty and CTRL.ie=1

## Operation
- Input path:
  - `spi_clk_in` and `spi_din` each pass through a 2-flop synchronizer.
  - A rising edge is detected as synced clk =1 while the previous synced clk =0.
  - On each rising edge with CTRL.en=1, synced data is shifted in LSB-side (`sh <= {sh[30:0], d}`) and `bit_cnt` increments.
  - When `bit_cnt`=31 on an edge, the assembled word (including that bit) is pushed to the FIFO and `bit_cnt` wraps to 0.
- Idle timeout:
  - `idle_cnt` clears on every rising edge and otherwise increments, saturating at 255.
  - If `bit_cnt`≠0, CTRL.timeout≠0 and `idle_cnt`==CTRL.timeout, the partial word is discarded, `bit_cnt`<=0 and STATUS.ferr<=1.
- Registers (`addr`):
  - 0 STATUS, read: [0] nempty, [1] full, [2] ovr, [3] ferr, [4] busy (`bit_cnt`≠0), [9:5] count, remaining bits 0.
  - 0 STATUS, write: write-1-to-clear on bits [3:2]; other bits ignored.
  - 1 DATA, read: FIFO head, or 0 if empty. `rd_en`=1 with `cs_n`=0 pops the entry; a pop when empty is ignored. Writes are ignored.
  - 2 CTRL, read/write: [0] en, [1] ie, [2] flush, [15:8] timeout.
    - flush is self-clearing: reads back 0, empties the FIFO and clears `bit_cnt`/`sh`.
    - en=0 ignores edges and holds the partial word.
  - 3: reads 0; writes are ignored.
- Overrun: when a word completes with the FIFO full and no pop in the same cycle, the word is dropped, the FIFO is unchanged and ovr<=1.
- Simultaneous events:
  - Push and pop in the same cycle both occur and count is unchanged; this holds when full, with no overrun.
  - A flush and a push in the same cycle: flush wins and the word is lost.
  - A W1C on ovr/ferr in the same cycle as a new set: set wins.
  - A timeout and an edge in the same cycle: the edge wins, since it clears `idle_cnt`.
- Reset values:
  - All state cleared: FIFO empty, `bit_cnt`=0, `sh`=0, STATUS flags 0.
  - CTRL=0x0000_0001 (en=1, ie=0, timeout=0, i.e. disabled).
  - `irq`=0; `data_out`=Z while `cs_n`=1.
- Reset mid-word: the partial word is lost. The synchronizers clear to 0, so a `spi_clk_in` already high at release produces one spurious rising edge two cycles later. Software flushes after reset when the line is active.

## Timing
- `data_out` is combinational from `addr`/`cs_n`/register state. No read wait states.
- All register writes and pops take effect on the `clk` edge where `write_en`/`rd_en` is sampled.
- Latency from the `spi_clk_in` rising edge to the bit shifted: 3 `clk` edges (2 sync + 1 detect/shift).
- Final bit to STATUS.nempty/`irq` visible: same edge as the shift of bit 31.
- Supported bit clock: high and low phases ≥2 `clk` cycles each. This covers transmitter divider ≥4.
- Data must be stable from 1 `clk` before to 2 `clk` after the rising edge. The transmitter changes data on falling edges, which satisfies this.

## Structure
- Package `spi_rx_pkg`:
  - Address constants `SPI_RX_STATUS`/`DATA`/`CTRL`.
  - STATUS and CTRL bit-index constants.
  - CTRL reset value.
- Sub-module `sync_fifo` (params `WIDTH`, `DEPTH`):
  - push/pop/flush inputs; head, count, full, empty outputs.
  - Pointers are log2(`DEPTH`) bits with wrap-around; count is log2(`DEPTH`)+1 bits.
- Synchronizers, edge detect, shift/count, timeout and register file live in `spi_rx`.

## Test plan
- Loopback, transmitter div=4, send 0xA5A5_0F0F → STATUS=0x0000_0021 (nempty, count=1); `irq`=1 with ie=1; DATA read with `rd_en` returns 0xA5A5_0F0F, then STATUS=0.
- Send 5 words 1..5 with no reads → count=4, full=1, ovr=1; four pops return 1,2,3,4. Write 0x4 to STATUS → ovr clears.
- CTRL.timeout=16, drive 10 edges then stop → ferr=1 within 19 cycles of the last edge; busy=0, count=0. A following full word is received correctly.
- FIFO full, pop issued on the same `clk` edge that bit 31 shifts → no ovr, count stays 4, popped word = oldest, newest word = tail.
- Assert `rst` after 17 bits, release, write flush → STATUS=0, CTRL=0x1. Next 32-bit word is received intact.
- en=0 during 8 edges, then en=1 and 32 edges → exactly one word, built from the post-enable bits only.
